// File: rtl/plane_setup_seq.sv
// plane_setup_seq: plane-equation setup (ddx, ddy, c) from three vertices using iterative restoring divides.
// Define PLANE_SETUP_PARALLEL_DIV_EN to run both divides concurrently in a single DIV_XY state.

module plane_setup_div #(
  parameter int W = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic signed [W-1:0] num,
  input  logic signed [W-1:0] den,
  output logic signed [31:0]  quot_next
);
  logic [W:0]   rem_reg;
  logic [W-1:0] quo_reg;
  logic [W-1:0] den_reg;
  logic         neg_reg;
  logic [W:0]   trial;
  logic         fits;
  logic [W-1:0] quo_step;

  // quot_next is the sign-fixed quotient as it will stand after this cycle's step.
  always_comb begin
    trial     = {rem_reg[W-1:0], quo_reg[W-1]};
    fits      = (trial >= {1'b0, den_reg});
    quo_step  = {quo_reg[W-2:0], fits};
    quot_next = neg_reg ? -quo_step[31:0] : quo_step[31:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rem_reg <= '0;
      quo_reg <= '0;
      den_reg <= '0;
      neg_reg <= 1'b0;
    end else if (load) begin
      rem_reg <= '0;
      quo_reg <= num[W-1] ? -num : num;
      den_reg <= den[W-1] ? -den : den;
      neg_reg <= num[W-1] ^ den[W-1];
    end else begin
      rem_reg <= fits ? (trial - {1'b0, den_reg}) : trial;
      quo_reg <= quo_step;
    end
  end
endmodule

module plane_setup_seq #(
  parameter int DIV_BITS = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [7:0]         frac_bits,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] fx1, fx2, fx3,
  input  logic signed [31:0] fy1, fy2, fy3,
  input  logic signed [31:0] fz1, fz2, fz3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] fddx,
  output logic signed [31:0] fddy,
  output logic signed [31:0] small_c,
  output logic               degenerate,
  output logic               busy
);
  typedef enum logic [3:0] {IDLE, DIFF, MUL, CROSS, DIV_X, DIV_Y, DIV_XY, CONST, DONE} state_t;

`ifdef PLANE_SETUP_PARALLEL_DIV_EN
  localparam int     NDIV      = 2;
  localparam state_t DIV_FIRST = DIV_XY;
`else
  localparam int     NDIV      = 1;
  localparam state_t DIV_FIRST = DIV_X;
`endif
  localparam int             CW       = $clog2(DIV_BITS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV_BITS - 1);

  state_t state_reg, state_next;

  logic [7:0]         f_reg;
  logic signed [31:0] x1_reg, y1_reg, z1_reg, x2_reg, y2_reg, z2_reg, x3_reg, y3_reg, z3_reg;
  logic signed [31:0] dx2_reg, dx3_reg, dy2_reg, dy3_reg, dz2_reg, dz3_reg;
  logic signed [47:0] prod_reg [6];
  logic signed [31:0] mul_a [6];
  logic signed [31:0] mul_b [6];
  logic signed [47:0] aa_c, ba_c, cc_c;
  logic signed [31:0] ddx_reg, ddy_reg, c_next;
  logic               deg_reg;
  logic [CW-1:0]      cnt_reg;
  logic               cnt_last;

  logic                       div_load;
  logic signed [DIV_BITS-1:0] div_num [NDIV];
  logic signed [DIV_BITS-1:0] div_den;
  logic signed [31:0]         div_q [NDIV];

  function automatic logic signed [47:0] mul_shift(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input logic [7:0] f);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    p = p >>> f;
    return p[47:0];
  endfunction

  function automatic logic signed [31:0] scale_shift(input logic signed [31:0] a,
                                                     input logic signed [31:0] b,
                                                     input logic [7:0] f);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    p = p >>> f;
    return p[31:0];
  endfunction

  function automatic logic signed [DIV_BITS-1:0] sext_div(input logic signed [47:0] v);
    return $signed({{(DIV_BITS-48){v[47]}}, v});
  endfunction

  function automatic logic signed [DIV_BITS-1:0] numer(input logic signed [47:0] v,
                                                       input logic [7:0] f);
    logic signed [DIV_BITS-1:0] e;
    e = sext_div(v);
    return e <<< f;
  endfunction

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign cnt_last = (cnt_reg == CNT_LAST);

  always_comb begin
    mul_a = '{dz3_reg, dz2_reg, dx3_reg, dx2_reg, dx3_reg, dx2_reg};
    mul_b = '{dy2_reg, dy3_reg, dz2_reg, dz3_reg, dy2_reg, dy3_reg};
    aa_c  = prod_reg[0] - prod_reg[1];
    ba_c  = prod_reg[2] - prod_reg[3];
    cc_c  = prod_reg[4] - prod_reg[5];
    c_next = z1_reg - scale_shift(ddx_reg, x1_reg, f_reg) - scale_shift(ddy_reg, y1_reg, f_reg);
  end

`ifdef PLANE_SETUP_PARALLEL_DIV_EN
  assign div_load   = (state_reg == CROSS);
  assign div_num[0] = numer(aa_c, f_reg);
  assign div_num[1] = numer(ba_c, f_reg);
  assign div_den    = sext_div(cc_c);
`else
  logic signed [47:0] ba_reg, cc_reg;
  // The shared divider is reloaded with Ba on the last DIV_X cycle.
  assign div_load   = (state_reg == CROSS) || ((state_reg == DIV_X) && cnt_last);
  assign div_num[0] = (state_reg == CROSS) ? numer(aa_c, f_reg) : numer(ba_reg, f_reg);
  assign div_den    = (state_reg == CROSS) ? sext_div(cc_c) : sext_div(cc_reg);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ba_reg <= '0;
      cc_reg <= '0;
    end else if (state_reg == CROSS) begin
      ba_reg <= ba_c;
      cc_reg <= cc_c;
    end
  end
`endif

  for (genvar gi = 0; gi < NDIV; gi++) begin : g_div
    plane_setup_div #(.W(DIV_BITS)) u_div (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (div_load),
      .num      (div_num[gi]),
      .den      (div_den),
      .quot_next(div_q[gi])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (in_valid) state_next = DIFF;
      DIFF:   state_next = MUL;
      MUL:    state_next = CROSS;
      CROSS:  state_next = (cc_c == '0) ? CONST : DIV_FIRST;
      DIV_X:  if (cnt_last) state_next = DIV_Y;
      DIV_Y:  if (cnt_last) state_next = CONST;
      DIV_XY: if (cnt_last) state_next = CONST;
      CONST:  state_next = DONE;
      DONE:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      fddx       <= '0;
      fddy       <= '0;
      small_c    <= '0;
      degenerate <= 1'b0;
      f_reg      <= '0;
      {x1_reg, y1_reg, z1_reg, x2_reg, y2_reg, z2_reg, x3_reg, y3_reg, z3_reg} <= '0;
      {dx2_reg, dx3_reg, dy2_reg, dy3_reg, dz2_reg, dz3_reg} <= '0;
      for (int i = 0; i < 6; i++) prod_reg[i] <= '0;
      ddx_reg <= '0;
      ddy_reg <= '0;
      deg_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          f_reg  <= frac_bits;
          x1_reg <= fx1; y1_reg <= fy1; z1_reg <= fz1;
          x2_reg <= fx2; y2_reg <= fy2; z2_reg <= fz2;
          x3_reg <= fx3; y3_reg <= fy3; z3_reg <= fz3;
        end
        DIFF: begin
          dx2_reg <= x2_reg - x1_reg; dx3_reg <= x3_reg - x1_reg;
          dy2_reg <= y2_reg - y1_reg; dy3_reg <= y3_reg - y1_reg;
          dz2_reg <= z2_reg - z1_reg; dz3_reg <= z3_reg - z1_reg;
        end
        MUL: for (int i = 0; i < 6; i++) prod_reg[i] <= mul_shift(mul_a[i], mul_b[i], f_reg);
        CROSS: begin
          cnt_reg <= '0;
          deg_reg <= (cc_c == '0);
          if (cc_c == '0) begin
            ddx_reg <= '0;
            ddy_reg <= '0;
          end
        end
        DIV_X: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_last) ddx_reg <= div_q[0];
        end
        DIV_Y: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_last) ddy_reg <= div_q[0];
        end
        DIV_XY: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_last) begin
            ddx_reg <= div_q[0];
            ddy_reg <= div_q[NDIV-1];
          end
        end
        CONST: begin
          fddx       <= ddx_reg;
          fddy       <= ddy_reg;
          small_c    <= c_next;
          degenerate <= deg_reg;
          out_valid  <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_plane_setup_seq.sv
// Self-checking bench for plane_setup_seq: directed spec cases plus random triangles against an arithmetic model.
module tb_plane_setup_seq;
  logic               clock = 1'b0;
  logic               reset_n;
  logic [7:0]         frac_bits;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] fx1, fx2, fx3, fy1, fy2, fy3, fz1, fz2, fz3;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] fddx, fddy, small_c;
  logic               degenerate;
  logic               busy;

  plane_setup_seq dut (
    .clock(clock), .reset_n(reset_n), .frac_bits(frac_bits),
    .in_valid(in_valid), .in_ready(in_ready),
    .fx1(fx1), .fx2(fx2), .fx3(fx3),
    .fy1(fy1), .fy2(fy2), .fy3(fy3),
    .fz1(fz1), .fz2(fz2), .fz3(fz3),
    .out_valid(out_valid), .out_ready(out_ready),
    .fddx(fddx), .fddy(fddy), .small_c(small_c),
    .degenerate(degenerate), .busy(busy)
  );

  always #5 clock = ~clock;

`ifdef PLANE_SETUP_PARALLEL_DIV_EN
  localparam int NORMAL_LAT = 69;
`else
  localparam int NORMAL_LAT = 133;
`endif
  localparam int DEGEN_LAT = 5;

  int tests = 0;
  int fails = 0;
  int tv[9];   // x1,y1,z1,x2,y2,z2,x3,y3,z3
  int tf;
  int lat;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint t48(input longint v);
    return (v <<< 16) >>> 16;
  endfunction

  // Plane setup computed directly from the arithmetic rules with 64-bit integers.
  function automatic void model(output int m_ddx, output int m_ddy, output int m_c, output bit m_deg);
    int dx2, dx3, dy2, dy3, dz2, dz3;
    longint aa, ba, cc;
    dx2 = tv[3] - tv[0]; dx3 = tv[6] - tv[0];
    dy2 = tv[4] - tv[1]; dy3 = tv[7] - tv[1];
    dz2 = tv[5] - tv[2]; dz3 = tv[8] - tv[2];
    aa = t48(t48((longint'(dz3) * longint'(dy2)) >>> tf) - t48((longint'(dz2) * longint'(dy3)) >>> tf));
    ba = t48(t48((longint'(dx3) * longint'(dz2)) >>> tf) - t48((longint'(dx2) * longint'(dz3)) >>> tf));
    cc = t48(t48((longint'(dx3) * longint'(dy2)) >>> tf) - t48((longint'(dx2) * longint'(dy3)) >>> tf));
    if (cc == 0) begin
      m_ddx = 0; m_ddy = 0; m_deg = 1'b1;
    end else begin
      m_ddx = int'((aa <<< tf) / cc);
      m_ddy = int'((ba <<< tf) / cc);
      m_deg = 1'b0;
    end
    m_c = tv[2] - int'((longint'(m_ddx) * longint'(tv[0])) >>> tf)
                - int'((longint'(m_ddy) * longint'(tv[1])) >>> tf);
  endfunction

  task automatic set_tri(input int x1, input int y1, input int z1, input int x2, input int y2,
                         input int z2, input int x3, input int y3, input int z3, input int f);
    tv = '{x1, y1, z1, x2, y2, z2, x3, y3, z3};
    tf = f;
  endtask

  task automatic drive_verts();
    fx1 = tv[0]; fy1 = tv[1]; fz1 = tv[2];
    fx2 = tv[3]; fy2 = tv[4]; fz2 = tv[5];
    fx3 = tv[6]; fy3 = tv[7]; fz3 = tv[8];
    frac_bits = 8'(tf);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen (or stop_at is reached).
  task automatic run_tri(input string tag, input int stop_at);
    int n;
    drive_verts();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".in_ready"}, in_ready, 1);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        fx1 = int'($urandom); fy1 = int'($urandom); fz1 = int'($urandom);
        fx2 = int'($urandom); fy2 = int'($urandom); fz2 = int'($urandom);
        fx3 = int'($urandom); fy3 = int'($urandom); fz3 = int'($urandom);
        frac_bits = 8'($urandom_range(0, 20));
      end
    end while (!out_valid && lat < 400 && lat != stop_at);
  endtask

  task automatic check_result(input string tag, input int e_ddx, input int e_ddy, input int e_c,
                              input bit e_deg);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".latency"}, lat, e_deg ? DEGEN_LAT : NORMAL_LAT);
    chk({tag, ".fddx"}, fddx, e_ddx);
    chk({tag, ".fddy"}, fddy, e_ddy);
    chk({tag, ".small_c"}, small_c, e_c);
    chk({tag, ".degenerate"}, degenerate, e_deg);
    $display("[TB] tri %s: ddx=%0d ddy=%0d c=%0d deg=%0d lat=%0d", tag, fddx, fddy, small_c, degenerate, lat);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, ".released"}, out_valid, 0);
    chk({tag, ".in_ready_after"}, in_ready, 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".fddx"}, fddx, 0);
    chk({tag, ".fddy"}, fddy, 0);
    chk({tag, ".small_c"}, small_c, 0);
    chk({tag, ".degenerate"}, degenerate, 0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_ddx, e_ddy, e_c;
    bit e_deg;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_verts();
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    reset_n = 1'b1;
    @(negedge clock);

    set_tri(0, 0, 10, 4, 0, 18, 0, 4, 30, 0);
    run_tri("int_plane", 0);
    check_result("int_plane", 2, 5, 10, 1'b0);

    // Backpressure: new vertices offered while the result is pending must be ignored.
    set_tri(7, 3, 100, -9, 22, 40, 15, -6, 8, 2);
    drive_verts();
    in_valid = 1'b1;
    repeat (10) @(negedge clock);
    chk("bp.fddx", fddx, 2);
    chk("bp.fddy", fddy, 5);
    chk("bp.small_c", small_c, 10);
    chk("bp.in_ready", in_ready, 0);
    chk("bp.out_valid", out_valid, 1);
    in_valid = 1'b0;
    release_out("bp");
    chk("bp.busy_after", busy, 0);
    chk("bp.hold_fddx", fddx, 2);

    set_tri(0, 0, 2560, 1024, 0, 4608, 0, 1024, 7680, 8);
    run_tri("fixed_plane", 0);
    check_result("fixed_plane", 512, 1280, 2560, 1'b0);
    release_out("fixed_plane");

    set_tri(0, 0, 0, 2, 0, -7, 0, 1, 0, 0);
    run_tri("trunc", 0);
    check_result("trunc", -3, 0, 0, 1'b0);
    release_out("trunc");

    set_tri(0, 0, 5, 1, 1, 9, 2, 2, 13, 0);
    run_tri("degen", 0);
    check_result("degen", 0, 0, 5, 1'b1);
    release_out("degen");

    // Reset in the middle of the first divide.
    set_tri(0, 0, 10, 4, 0, 18, 0, 4, 30, 0);
    run_tri("mid_reset", 40);
    chk("mid_reset.busy_before", busy, 1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_reset_state("mid_reset");
    run_tri("after_reset", 0);
    check_result("after_reset", 2, 5, 10, 1'b0);
    release_out("after_reset");

    for (int k = 0; k < 10; k++) begin
      int x1, y1, x2, y2, x3, y3;
      x1 = int'($urandom_range(0, 4000)) - 2000; y1 = int'($urandom_range(0, 4000)) - 2000;
      x2 = int'($urandom_range(0, 4000)) - 2000; y2 = int'($urandom_range(0, 4000)) - 2000;
      if (k % 4 == 3) begin
        x3 = 2 * x2 - x1; y3 = 2 * y2 - y1;
      end else begin
        x3 = int'($urandom_range(0, 4000)) - 2000; y3 = int'($urandom_range(0, 4000)) - 2000;
      end
      set_tri(x1, y1, int'($urandom_range(0, 200000)) - 100000,
              x2, y2, int'($urandom_range(0, 200000)) - 100000,
              x3, y3, int'($urandom_range(0, 200000)) - 100000,
              int'($urandom_range(0, 10)));
      model(e_ddx, e_ddy, e_c, e_deg);
      run_tri($sformatf("rand%0d", k), 0);
      check_result($sformatf("rand%0d", k), e_ddx, e_ddy, e_c, e_deg);
      release_out($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
